alu_seq: RTL and testbench

Parametrised, handshaked multi-cycle ALU for the datapath. It accepts one operation per transaction over a valid/ready input port and computes it in one or more cycles. Shifts run iteratively, one bit per cycle, and multiply runs as shift-add. The result and the flags are held in an output register until the consumer takes them. It sits between operand fetch and writeback, and the sequencer stalls on `ready_o`/`valid_o`.

---
 rtl/alu_seq.sv | 206 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith, bit-serial shifts, optional shift-add multiply.
// Define ALU_MUL_EN to build the multiplier (opcode 1000); otherwise opcode 1000 is illegal.
//   state    | meaning
//   ST_IDLE  | ready for a new operation
//   ST_SHIFT | shifting acc one bit per cycle
//   ST_MUL   | shift-add multiply in progress
//   ST_DONE  | result and flags held until taken
module alu_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  input  logic [3:0]            opcode_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ALU_zero,
  output logic                  negative,
  output logic                  carry_o,
  output logic                  overflow_o
);

  localparam int MSB = DATA_WIDTH - 1;
  localparam int CW  = (SHAMT_WIDTH > $clog2(DATA_WIDTH)) ? SHAMT_WIDTH : $clog2(DATA_WIDTH) + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL, ST_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [3:0]            r_op, w_op_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_zero, r_neg, r_carry, r_ovf;
`ifdef ALU_MUL_EN
  logic [DATA_WIDTH-1:0] r_mcand, w_mcand_nxt, r_mplier, w_mplier_nxt, w_macc;
`endif

  logic [DATA_WIDTH:0]   w_sum, w_diff;
  logic [DATA_WIDTH-1:0] w_shifted, w_res;
  logic [CW-1:0]         w_shamt;
  logic                  w_bneg_msb, w_load, w_carry, w_ovf;

  assign w_shamt = CW'(B_i[SHAMT_WIDTH-1:0]);
  assign w_sum   = {1'b0, A_i} + {1'b0, B_i};
  assign w_diff  = {1'b0, A_i} + {1'b0, ~B_i} + (DATA_WIDTH+1)'(1);
  // Sign of -B: negation flips the sign except for 0 and the most negative value.
  assign w_bneg_msb = (B_i[MSB-1:0] == '0) ? B_i[MSB] : ~B_i[MSB];
`ifdef ALU_MUL_EN
  assign w_macc = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

  always_comb begin
    w_shifted = {r_acc[MSB-1:0], 1'b0};
    case (r_op)
      OP_SRL:  w_shifted = {1'b0, r_acc[MSB:1]};
      OP_SRA:  w_shifted = {r_acc[MSB], r_acc[MSB:1]};
      default: w_shifted = {r_acc[MSB-1:0], 1'b0};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
`ifdef ALU_MUL_EN
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
`endif
    w_res   = '0;
    w_load  = 1'b0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid_i) begin
          w_op_nxt    = opcode_i;
          w_state_nxt = ST_DONE;
          w_load      = 1'b1;
          case (opcode_i)
            OP_ADD: begin
              w_res   = w_sum[MSB:0];
              w_carry = w_sum[DATA_WIDTH];
              w_ovf   = (A_i[MSB] == B_i[MSB]) && (w_sum[MSB] != A_i[MSB]);
            end
            OP_SUB: begin
              w_res   = w_diff[MSB:0];
              w_carry = w_diff[DATA_WIDTH];
              w_ovf   = (A_i[MSB] == w_bneg_msb) && (w_diff[MSB] != A_i[MSB]);
            end
            OP_AND: w_res = A_i & B_i;
            OP_OR:  w_res = A_i | B_i;
            OP_XOR: w_res = A_i ^ B_i;
            OP_SRL, OP_SRA, OP_SLL: begin
              if (w_shamt == '0) begin
                w_res = A_i;
              end else begin
                w_load      = 1'b0;
                w_acc_nxt   = A_i;
                w_cnt_nxt   = w_shamt;
                w_state_nxt = ST_SHIFT;
              end
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
              w_load       = 1'b0;
              w_acc_nxt    = '0;
              w_mcand_nxt  = A_i;
              w_mplier_nxt = B_i;
              w_cnt_nxt    = CW'(DATA_WIDTH);
              w_state_nxt  = ST_MUL;
            end
`endif
            default: w_res = '0;
          endcase
        end
      end
      ST_SHIFT: begin
        w_acc_nxt = w_shifted;
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_res       = w_shifted;
          w_load      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        w_acc_nxt    = w_macc;
        w_mcand_nxt  = {r_mcand[MSB-1:0], 1'b0};
        w_mplier_nxt = {1'b0, r_mplier[MSB:1]};
        w_cnt_nxt    = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_res       = w_macc;
          w_load      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_data  <= '0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef ALU_MUL_EN
      r_mcand  <= '0;
      r_mplier <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
`ifdef ALU_MUL_EN
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
`endif
      if (w_load) begin
        r_data  <= w_res;
        r_zero  <= (w_res == '0);
        r_neg   <= w_res[MSB];
        r_carry <= w_carry;
        r_ovf   <= w_ovf;
      end
    end
  end

  assign ready_o    = (r_state == ST_IDLE) && !rst_i;
  assign valid_o    = (r_state == ST_DONE);
  assign data_o     = r_data;
  assign ALU_zero   = r_zero;
  assign negative   = r_neg;
  assign carry_o    = r_carry;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results, a monitor pops them on each transfer.
// Expectations for opcode 1000 follow ALU_MUL_EN.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i, valid_i, ready_o, valid_o, ready_i;
  logic         ALU_zero, negative, carry_o, overflow_o;
  logic [W-1:0] A_i, B_i, data_o;
  logic [3:0]   opcode_i;

  alu_seq #(.DATA_WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .A_i(A_i), .B_i(B_i), .opcode_i(opcode_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .ALU_zero(ALU_zero), .negative(negative),
    .carry_o(carry_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] d;
    logic         z, n, c, v;
    string        nm;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge whenever valid_o && ready_i here.
  initial begin
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_i && valid_o && ready_i) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got data %0h expected no result", data_o);
        end else begin
          m_e = sb.pop_front();
          chk({m_e.nm, "_data"}, 64'(data_o),     64'(m_e.d));
          chk({m_e.nm, "_zero"}, 64'(ALU_zero),   64'(m_e.z));
          chk({m_e.nm, "_neg"},  64'(negative),   64'(m_e.n));
          chk({m_e.nm, "_carry"},64'(carry_o),    64'(m_e.c));
          chk({m_e.nm, "_ovf"},  64'(overflow_o), 64'(m_e.v));
        end
      end
    end
  end

  task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_d, input logic c,
                        input logic v, input int lat, input int hold);
    exp_t e;
    int   cyc;
    @(negedge clk_i);
    chk({nm, "_ready_before"}, 64'(ready_o), 64'(1));
    valid_i  = 1'b1;
    A_i      = a;
    B_i      = b;
    opcode_i = op;
    ready_i  = (hold == 0);
    e.d = exp_d; e.z = (exp_d == '0); e.n = exp_d[W-1]; e.c = c; e.v = v; e.nm = nm;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    valid_i  = 1'b0;
    A_i      = $urandom;
    B_i      = $urandom;
    opcode_i = 4'($urandom_range(0, 15));
    cyc = 1;
    while (!valid_o && cyc < 200) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
    chk({nm, "_latency"}, 64'(cyc), 64'(lat));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk_i);
        chk({nm, "_hold_ready"}, 64'(ready_o), 64'(0));
        chk({nm, "_hold_valid"}, 64'(valid_o), 64'(1));
        chk({nm, "_hold_data"},  64'(data_o),  64'(exp_d));
        valid_i  = 1'b1;
        A_i      = $urandom;
        B_i      = $urandom;
        opcode_i = 4'($urandom_range(0, 15));
      end
      @(negedge clk_i);
      valid_i = 1'b0;
      ready_i = 1'b1;
    end
    @(posedge clk_i);
    #1;
    chk({nm, "_ready_after"}, 64'(ready_o), 64'(1));
  endtask

  task automatic reset_mid(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    @(negedge clk_i);
    valid_i  = 1'b1;
    A_i      = a;
    B_i      = b;
    opcode_i = op;
    ready_i  = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    chk({nm, "_busy_valid"}, 64'(valid_o), 64'(0));
    chk({nm, "_busy_ready"}, 64'(ready_o), 64'(0));
    rst_i = 1'b1;
    #1;
    chk({nm, "_rst_valid"}, 64'(valid_o), 64'(0));
    chk({nm, "_rst_data"},  64'(data_o),  64'(0));
    chk({nm, "_rst_ready"}, 64'(ready_o), 64'(0));
    chk({nm, "_rst_flags"}, 64'({ALU_zero, negative, carry_o, overflow_o}), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk({nm, "_rel_ready"}, 64'(ready_o), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i    = 1'b1;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    A_i      = '0;
    B_i      = '0;
    opcode_i = '0;
    #12;
    chk("reset_valid", 64'(valid_o), 64'(0));
    chk("reset_ready", 64'(ready_o), 64'(0));
    chk("reset_data",  64'(data_o),  64'(0));
    chk("reset_flags", 64'({ALU_zero, negative, carry_o, overflow_o}), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;

    //      name        op     A             B             expected      c     v     lat hold
    run_op("add_ovf",   4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1,  1, 0);
    run_op("sub_eq",    4'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0,  1, 0);
    run_op("sub_neg",   4'd1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0,  1, 0);
    run_op("add_carry", 4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0,  1, 0);
    run_op("sub_ovf",   4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1,  1, 0);
    run_op("and",       4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0,  1, 0);
    run_op("or",        4'd3, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0,  1, 0);
    run_op("xor_hold",  4'd4, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0, 1'b0,  1, 10);
    run_op("sra_31",    4'd6, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 32, 0);
    run_op("sll_0",     4'd7, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0,  1, 0);
    run_op("srl_4",     4'd5, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0,  5, 0);
    run_op("sll_3",     4'd7, 32'h00000001, 32'h00000003, 32'h00000008, 1'b0, 1'b0,  4, 0);
    run_op("sra_pos",   4'd6, 32'h40000000, 32'h00000002, 32'h10000000, 1'b0, 1'b0,  3, 0);
    run_op("illegal",   4'd15,32'h00000005, 32'h00000006, 32'h00000000, 1'b0, 1'b0,  1, 0);
`ifdef ALU_MUL_EN
    run_op("mul",       4'd8, 32'h00010001, 32'h00010001, 32'h00020001, 1'b0, 1'b0, 33, 0);
    run_op("mul_neg",   4'd8, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, 1'b0, 1'b0, 33, 0);
    reset_mid("rst_mul", 4'd8, 32'h00010001, 32'h00010001);
`else
    run_op("mul_off",   4'd8, 32'h00010001, 32'h00010001, 32'h00000000, 1'b0, 1'b0,  1, 0);
`endif
    run_op("or_pre",    4'd3, 32'h00000100, 32'h00000001, 32'h00000101, 1'b0, 1'b0,  1, 0);
    reset_mid("rst_shift", 4'd7, 32'h00000001, 32'h00000014);
    run_op("add_post",  4'd0, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0,  1, 0);

    repeat (3) @(negedge clk_i);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
